// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Purpose  : HI/LO sequencer for EXE: iterative mul/div, held result, one-shot commit
// Revision : 1.0
// ============================================================================
module hilo_muldiv_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        accept,
   input  logic        wr_disable,
   input  logic        flush,
   output logic        ready,
   output logic        busy,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_W = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // quo_q holds the multiplicand or the dividend shifting into the quotient;
   // dvs_q holds the multiplier or the divisor magnitude.
   logic [31:0]      quo_q, quo_d;
   logic [31:0]      rem_q, rem_d;
   logic [31:0]      dvs_q, dvs_d;
   logic             sgn_q, sgn_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             dz_q, dz_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      phi_q, phi_d;
   logic [31:0]      plo_q, plo_d;

   logic        w_req_signed;
   logic        w_s1, w_s2;
   logic [31:0] w_abs1, w_abs2;
   logic [32:0] w_trial, w_diff;
   logic        w_ge;
   logic [31:0] w_rem_nx, w_quo_nx;
   logic [63:0] w_prod;
   logic        w_commit;

   assign w_req_signed = ~req_op[0];
   assign w_s1         = w_req_signed & src1[31];
   assign w_s2         = w_req_signed & src2[31];
   assign w_abs1       = w_s1 ? -src1 : src1;
   assign w_abs2       = w_s2 ? -src2 : src2;

   assign w_trial  = {rem_q, quo_q[31]};
   assign w_diff   = w_trial - {1'b0, dvs_q};
   assign w_ge     = ~w_diff[32];
   assign w_rem_nx = w_ge ? w_diff[31:0] : w_trial[31:0];
   assign w_quo_nx = {quo_q[30:0], w_ge};

   assign w_prod = {{32{sgn_q & quo_q[31]}}, quo_q} * {{32{sgn_q & dvs_q[31]}}, dvs_q};

   assign w_commit = accept & ~wr_disable & ~flush;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      sgn_d   = sgn_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && !req_op[2]) begin
               sgn_d = w_req_signed;
               if (!req_op[1]) begin
                  quo_d   = src1;
                  dvs_d   = src2;
                  cnt_d   = CNT_W'(MUL_CYCLES - 1);
                  state_d = S_MUL;
               end else begin
                  quo_d   = w_abs1;
                  dvs_d   = w_abs2;
                  rem_d   = '0;
                  s1_d    = w_s1;
                  s2_d    = w_s2;
                  dz_d    = (src2 == 32'd0);
                  cnt_d   = CNT_W'(DIV_CYCLES - 1);
                  state_d = S_DIV;
               end
            end else if (req_valid && w_commit) begin
               if (req_op == 3'd4) hi_d = src1;
               if (req_op == 3'd5) lo_d = src1;
            end
         end
         S_MUL: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               phi_d   = w_prod[63:32];
               plo_d   = w_prod[31:0];
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            rem_d = w_rem_nx;
            quo_d = w_quo_nx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               // With a zero divisor the remainder ends as |src1|; re-signing it restores src1.
               plo_d   = dz_q ? 32'hFFFF_FFFF : ((s1_q ^ s2_q) ? -w_quo_nx : w_quo_nx);
               phi_d   = s1_q ? -w_rem_nx : w_rem_nx;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         default: begin
            if (accept) begin
               if (w_commit) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
               state_d = S_IDLE;
            end
         end
      endcase

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         sgn_q   <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         sgn_q   <= sgn_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end

   assign ready = ((state_q == S_IDLE) && req_valid && req_op[2]) || (state_q == S_DONE);
   assign busy  = (state_q == S_MUL) || (state_q == S_DIV);
   assign hi    = hi_q;
   assign lo    = lo_q;

   always_comb begin
      result = lo_q;
      if (state_q == S_DONE) begin
         result = plo_q;
      end else if ((state_q == S_IDLE) && req_valid) begin
         case (req_op)
            3'd5:    result = src1;
            3'd6:    result = hi_q;
            default: result = lo_q;
         endcase
      end
   end

   a_req_held: assert property (@(posedge clk) disable iff (reset) busy |-> (req_valid || flush));

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_ctrl
// Purpose  : Directed + randomized bench for hilo_muldiv_ctrl with a transaction-level model
// Revision : 1.0
// ============================================================================
module tb_hilo_muldiv_ctrl;

   localparam int MUL_CYCLES = 4;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        accept;
   logic        wr_disable;
   logic        flush;
   logic        ready;
   logic        busy;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;

   hilo_muldiv_ctrl #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (32)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .src1       (src1),
      .src2       (src2),
      .accept     (accept),
      .wr_disable (wr_disable),
      .flush      (flush),
      .ready      (ready),
      .busy       (busy),
      .result     (result),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {HI, LO}
   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int          q, r;
      p = '0;
      case (op)
         3'd0: p = longint'($signed(a)) * longint'($signed(b));
         3'd1: p = {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 32'd0)                                p = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
            else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               p = {r, q};
            end
         end
         3'd3: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else            p = {a % b, a / b};
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   // Transaction-level model: 0 idle, 1 computing (m_left edges to go), 2 result held
   int          m_phase;
   int          m_left;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0; m_left = 0;
         m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
      end else if (flush) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (req_valid) begin
               if (req_op < 3'd4) begin
                  {m_phi, m_plo} = ref_op(req_op, src1, src2);
                  m_left  = (req_op < 3'd2) ? MUL_CYCLES : 32;
                  m_phase = 1;
               end else if (accept && !wr_disable) begin
                  if (req_op == 3'd4) m_hi = src1;
                  if (req_op == 3'd5) m_lo = src1;
               end
            end
            1: begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            default: if (accept) begin
               if (!wr_disable) begin
                  m_hi = m_phi;
                  m_lo = m_plo;
               end
               m_phase = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      logic e_ready;
      if (chk_en) begin
         e_ready = ((m_phase == 0) && req_valid && (req_op >= 3'd4)) || (m_phase == 2);
         check("ready", {31'd0, ready}, {31'd0, e_ready});
         check("busy", {31'd0, busy}, {31'd0, (m_phase == 1)});
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         if (m_phase == 2)
            check("result_done", result, m_plo);
         else if (m_phase == 0 && req_valid && req_op == 3'd6)
            check("result_mfhi", result, m_hi);
         else if (m_phase == 0 && req_valid && req_op == 3'd7)
            check("result_mflo", result, m_lo);
      end
   end

   // Presents one request; lat = cycles from the issuing cycle to the first ready cycle.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic wrd, input int flush_at,
                         output int lat, output bit reached);
      req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
      lat = 0; reached = 1'b0;
      forever begin
         if (lat == flush_at) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; req_valid = 1'b0;
            return;
         end
         @(negedge clk);
         if (ready) break;
         if (lat >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready (op %0d)", lat, op);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; req_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         lat++;
      end
      reached = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      accept = 1'b1; wr_disable = wrd;
      @(posedge clk); #1;
      accept = 1'b0; wr_disable = 1'b0; req_valid = 1'b0;
   endtask

   initial begin
      int lat;
      bit ok;
      #5_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      bit          ok;
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel, hold, fl;
      logic        wrd;

      reset = 1'b1; req_valid = 1'b0; req_op = '0; src1 = '0; src2 = '0;
      accept = 1'b0; wr_disable = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", result, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, -1, lat, ok);
      check("mult_lat", lat, 32'd5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);

      run_op(3'd3, 32'd100, 32'd7, 1, 1'b0, -1, lat, ok);
      check("divu_lat", lat, 32'd33);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, -1, lat, ok);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);

      run_op(3'd2, 32'd5, 32'd0, 0, 1'b0, -1, lat, ok);
      check("div0_lat", lat, 32'd33);
      check("div0_lo", lo, 32'hFFFF_FFFF);
      check("div0_hi", hi, 32'd5);

      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, -1, lat, ok);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);

      run_op(3'd3, 32'd1000, 32'd3, 0, 1'b0, 10, lat, ok);
      @(negedge clk);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_hi", hi, 32'd0);
      check("flush_lo", lo, 32'h8000_0000);
      @(posedge clk); #1;
      run_op(3'd5, 32'h1234, 32'd0, 0, 1'b0, -1, lat, ok);
      check("mtlo_lo", lo, 32'h1234);

      run_op(3'd1, 32'd2, 32'd3, 4, 1'b1, -1, lat, ok);
      @(negedge clk);
      check("wrdis_hi", hi, 32'd0);
      check("wrdis_lo", lo, 32'h1234);
      check("wrdis_idle_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;

      run_op(3'd4, 32'hAA, 32'd0, 0, 1'b0, -1, lat, ok);
      check("mthi_hi", hi, 32'hAA);
      req_valid = 1'b1; req_op = 3'd6;
      @(negedge clk);
      check("mfhi_ready", {31'd0, ready}, 32'd1);
      check("mfhi_result", result, 32'hAA);
      accept = 1'b1;
      @(posedge clk); #1;
      accept = 1'b0; req_valid = 1'b0;

      req_valid = 1'b1; req_op = 3'd2; src1 = 32'd77; src2 = 32'd5;
      repeat (6) begin @(posedge clk); #1; end
      reset = 1'b1; req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      @(negedge clk);
      check("rstdiv_hi", hi, 32'd0);
      check("rstdiv_lo", lo, 32'd0);
      check("rstdiv_ready", {31'd0, ready}, 32'd0);
      check("rstdiv_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      for (int t = 0; t < 150; t++) begin
         op   = 3'($urandom_range(0, 7));
         sel  = $urandom_range(0, 7);
         a    = $urandom;
         b    = $urandom;
         case (sel)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            3: begin a = -($urandom_range(1, 300)); b = $urandom_range(1, 20); end
            default: ;
         endcase
         hold = $urandom_range(0, 3);
         wrd  = ($urandom_range(0, 3) == 0);
         fl   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : -1;
         run_op(op, a, b, hold, wrd, fl, lat, ok);
         if (ok)
            check("rand_lat", lat, op[2] ? 32'd0 : (op[1] ? 32'd33 : MUL_CYCLES + 1));
      end

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
